pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage pipeline (IF/ID/EX/ME/WB).
- Replaces the flat opcode-scan stall logic with a state machine that handles two cases:
  - load-use interlocks, with a counted stall;
  - control-transfer freezes (beq/bne/blez/bgtz/bgez-class/j/jr) held until EX resolves them.
- Drives PC write enable, IF/ID enable, IF/ID squash and ID/EX bubble insertion.
- Keeps a saturating stall counter and a sticky watchdog error.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_id_hazard_decode.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode/function constants and FSM state type for the pipeline hazard controller.
// Holds the MIPS-style decode helpers used by the ID-stage hazard logic.
package pipe_hazard_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_JR     = 6'b001000;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_STALL  = 2'd1,
      CTRL_WAIT = 2'd2
   } hz_state_e;

   // Control transfers freeze fetch until EX resolves them; jr is the only R-type member.
   function automatic logic is_ctrl_op(input logic [5:0] op, input logic [5:0] fn);
      logic r;
      r = 1'b0;
      case (op)
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM, OP_J: r = 1'b1;
         OP_RTYPE: r = (fn == FN_JR);
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_id_hazard_decode.sv
// Combinational ID-stage decode: control-transfer detection, source-register usage
// and the load-use hazard against the instruction currently in EX.
module id_hazard_decode
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [31:0] instr_id,
   input  logic        id_valid,
   input  logic        ex_load,
   input  logic [4:0]  ex_wr_reg,
   output logic        is_ctrl,
   output logic        uses_rs,
   output logic        uses_rt,
   output logic        lu_haz
);

   logic [5:0] op;
   logic [5:0] fn;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       rs_hit;
   logic       rt_hit;
   logic       unused_imm_bits;

   assign op = instr_id[31:26];
   assign fn = instr_id[5:0];
   assign rs = instr_id[25:21];
   assign rt = instr_id[20:16];

   // rd/shamt/immediate bits never participate in hazard detection.
   assign unused_imm_bits = &{1'b0, instr_id[15:6]};

   always_comb begin
      is_ctrl = id_valid & is_ctrl_op(op, fn);
      uses_rs = (op != OP_J);
      uses_rt = 1'b0;
      case (op)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
         default:                         uses_rt = 1'b0;
      endcase
      rs_hit = uses_rs & (rs == ex_wr_reg);
      rt_hit = uses_rt & (rt == ex_wr_reg);
      // $zero is never a real dependency, so a load targeting it cannot interlock.
      lu_haz = id_valid & ex_load & (ex_wr_reg != 5'd0) & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock with counted stall, control-transfer
// freeze until EX resolves, saturating stall counter and sticky watchdog error.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int LU_CYCLES = 1,
   parameter int MAX_WAIT  = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr_id,
   input  logic             id_valid,
   input  logic             ex_load,
   input  logic [4:0]       ex_wr_reg,
   input  logic             br_resolve,
   input  logic             br_taken,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] LU_RELOAD = 2'(LU_CYCLES - 1);
   localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

   hz_state_e        state_q, state_d;
   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic [3:0]       wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic is_ctrl;
   logic uses_rs;
   logic uses_rt;
   logic lu_haz;
   logic unused_sigs;

   id_hazard_decode u_decode (
      .instr_id  (instr_id),
      .id_valid  (id_valid),
      .ex_load   (ex_load),
      .ex_wr_reg (ex_wr_reg),
      .is_ctrl   (is_ctrl),
      .uses_rs   (uses_rs),
      .uses_rt   (uses_rt),
      .lu_haz    (lu_haz)
   );

   // The datapath steers the PC itself on resolve; direction does not affect sequencing.
   assign unused_sigs = &{1'b0, br_taken, uses_rs, uses_rt};

   always_comb begin
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;

      case (state_q)
         RUN: begin
            // Load-use wins: a dependent control instruction stalls first, then re-decodes.
            if (lu_haz) begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_bubble = 1'b1;
               if (LU_CYCLES > 1) begin
                  state_d  = LU_STALL;
                  lu_cnt_d = LU_RELOAD;
               end
            end else if (is_ctrl) begin
               state_d    = CTRL_WAIT;
               wait_cnt_d = 4'd0;
            end
         end

         LU_STALL: begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            lu_cnt_d    = lu_cnt_q - 2'd1;
            if (lu_cnt_q == 2'd1) begin
               state_d = RUN;
            end
         end

         CTRL_WAIT: begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (br_resolve) begin
               pc_we   = 1'b1;
               state_d = RUN;
            end else if (wait_cnt_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = RUN;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         lu_cnt_q    <= 2'd0;
         wait_cnt_q  <= 4'd0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign busy      = (state_q != RUN);
   assign err       = err_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance a uses LU_CYCLES=1, instance b LU_CYCLES=2,
// both share stimulus; expected values are hand-derived per cycle.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 16;

   localparam logic [31:0] I_ADD_R2  = 32'h00441820;
   localparam logic [31:0] I_ADD_R0  = 32'h00041820;
   localparam logic [31:0] I_J       = 32'h08000010;
   localparam logic [31:0] I_BEQ     = 32'h10220003;
   localparam logic [31:0] I_JR31    = 32'h03E00008;
   localparam logic [31:0] I_SW_R5   = 32'hACC50000;
   localparam logic [31:0] I_LW_R5   = 32'h8CC50000;

   // {pc_we, ifid_we, ifid_flush, idex_bubble}
   localparam logic [3:0] O_RUN   = 4'b1100;
   localparam logic [3:0] O_STALL = 4'b0001;
   localparam logic [3:0] O_WAIT  = 4'b0110;
   localparam logic [3:0] O_RES   = 4'b1110;

   logic             clk;
   logic             rst_n;
   logic [31:0]      instr_id;
   logic             id_valid;
   logic             ex_load;
   logic [4:0]       ex_wr_reg;
   logic             br_resolve;
   logic             br_taken;

   logic             a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_busy, a_err;
   logic [CNT_W-1:0] a_stall_cnt;
   logic             b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_busy, b_err;
   logic [CNT_W-1:0] b_stall_cnt;

   int total;
   int bad;

   pipe_hazard_ctrl #(.LU_CYCLES(1), .MAX_WAIT(4), .CNT_W(CNT_W)) u_dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_id    (instr_id),
      .id_valid    (id_valid),
      .ex_load     (ex_load),
      .ex_wr_reg   (ex_wr_reg),
      .br_resolve  (br_resolve),
      .br_taken    (br_taken),
      .pc_we       (a_pc_we),
      .ifid_we     (a_ifid_we),
      .ifid_flush  (a_ifid_flush),
      .idex_bubble (a_idex_bubble),
      .busy        (a_busy),
      .err         (a_err),
      .stall_cnt   (a_stall_cnt)
   );

   pipe_hazard_ctrl #(.LU_CYCLES(2), .MAX_WAIT(4), .CNT_W(CNT_W)) u_dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_id    (instr_id),
      .id_valid    (id_valid),
      .ex_load     (ex_load),
      .ex_wr_reg   (ex_wr_reg),
      .br_resolve  (br_resolve),
      .br_taken    (br_taken),
      .pc_we       (b_pc_we),
      .ifid_we     (b_ifid_we),
      .ifid_flush  (b_ifid_flush),
      .idex_bubble (b_idex_bubble),
      .busy        (b_busy),
      .err         (b_err),
      .stall_cnt   (b_stall_cnt)
   );

   // Clock and time limit
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "time limit");
   end

   // Driver helpers
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic ld,
                        input logic [4:0] wr, input logic res);
      id_valid   = v;
      instr_id   = ins;
      ex_load    = ld;
      ex_wr_reg  = wr;
      br_resolve = res;
      br_taken   = res;
   endtask

   // Comparison points
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] exp_o, input logic exp_busy);
      chk({tag, ".a_outs"}, {28'd0, a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble}, {28'd0, exp_o});
      chk({tag, ".a_busy"}, {31'd0, a_busy}, {31'd0, exp_busy});
   endtask

   task automatic chk_b(input string tag, input logic [3:0] exp_o, input logic exp_busy);
      chk({tag, ".b_outs"}, {28'd0, b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble}, {28'd0, exp_o});
      chk({tag, ".b_busy"}, {31'd0, b_busy}, {31'd0, exp_busy});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_a("reset", O_RUN, 1'b0);
      chk("reset.err", {31'd0, a_err}, 32'd0);
      chk("reset.cnt", {16'd0, a_stall_cnt}, 32'd0);
      rst_n = 1'b1;
      next_cycle();

      // Load-use: lw $2 in EX, add $3,$2,$4 in ID, one stall cycle
      drive(1'b1, I_ADD_R2, 1'b1, 5'd2, 1'b0);
      settle();
      chk_a("lu.stall", O_STALL, 1'b0);
      next_cycle();
      drive(1'b1, I_ADD_R2, 1'b0, 5'd0, 1'b0);
      settle();
      chk_a("lu.after", O_RUN, 1'b0);
      chk("lu.cnt", {16'd0, a_stall_cnt}, 32'd1);
      next_cycle();

      // $zero exemption: load to $0 never interlocks
      drive(1'b1, I_ADD_R0, 1'b1, 5'd0, 1'b0);
      settle();
      chk_a("zero.nostall", O_RUN, 1'b0);
      next_cycle();
      chk("zero.cnt", {16'd0, a_stall_cnt}, 32'd1);

      // Jump with a load to $2 in EX: no interlock, enters control wait
      drive(1'b1, I_J, 1'b1, 5'd2, 1'b0);
      settle();
      chk_a("j.issue", O_RUN, 1'b0);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      settle();
      chk_a("j.wait", O_WAIT, 1'b1);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      settle();
      chk_a("j.resolve", O_RES, 1'b1);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      chk("j.busy_after", {31'd0, a_busy}, 32'd0);
      chk("j.cnt", {16'd0, a_stall_cnt}, 32'd2);

      // Branch: two wait cycles then resolve taken on the third
      drive(1'b1, I_BEQ, 1'b0, 5'd0, 1'b0);
      settle();
      chk_a("beq.issue", O_RUN, 1'b0);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         settle();
         chk_a($sformatf("beq.wait%0d", i), O_WAIT, 1'b1);
         next_cycle();
      end
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      settle();
      chk_a("beq.resolve", O_RES, 1'b1);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      settle();
      chk_a("beq.after", O_RUN, 1'b0);
      chk("beq.cnt", {16'd0, a_stall_cnt}, 32'd4);
      next_cycle();

      // Stray resolve while running is ignored and does not set err
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      settle();
      chk_a("stray.res", O_RUN, 1'b0);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      chk("stray.busy", {31'd0, a_busy}, 32'd0);
      chk("stray.err", {31'd0, a_err}, 32'd0);
      chk("stray.cnt", {16'd0, a_stall_cnt}, 32'd4);

      // Asynchronous reset in the middle of a control wait
      drive(1'b1, I_BEQ, 1'b0, 5'd0, 1'b0);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      next_cycle();
      chk("midrst.pre_busy", {31'd0, a_busy}, 32'd1);
      chk("midrst.pre_cnt", {16'd0, a_stall_cnt}, 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk_a("midrst", O_RUN, 1'b0);
      chk("midrst.cnt", {16'd0, a_stall_cnt}, 32'd0);
      chk("midrst.err", {31'd0, a_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Load then jr $31: instance a stalls once, instance b twice, both wait then resolve
      drive(1'b1, I_JR31, 1'b1, 5'd31, 1'b0);
      settle();
      chk_a("jr.A", O_STALL, 1'b0);
      chk_b("jr.A", O_STALL, 1'b0);
      next_cycle();
      drive(1'b1, I_JR31, 1'b0, 5'd0, 1'b0);
      settle();
      chk_a("jr.B", O_RUN, 1'b0);
      chk_b("jr.B", O_STALL, 1'b1);
      next_cycle();
      settle();
      chk_a("jr.C", O_WAIT, 1'b1);
      chk_b("jr.C", O_RUN, 1'b0);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      settle();
      chk_a("jr.D", O_WAIT, 1'b1);
      chk_b("jr.D", O_WAIT, 1'b1);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
      settle();
      chk_a("jr.E", O_RES, 1'b1);
      chk_b("jr.E", O_RES, 1'b1);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      chk("jr.a_busy", {31'd0, a_busy}, 32'd0);
      chk("jr.b_busy", {31'd0, b_busy}, 32'd0);
      chk("jr.a_cnt", {16'd0, a_stall_cnt}, 32'd3);
      chk("jr.b_cnt", {16'd0, b_stall_cnt}, 32'd3);

      // Watchdog: no resolve for four wait cycles
      drive(1'b1, I_BEQ, 1'b0, 5'd0, 1'b0);
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk_a($sformatf("wd.wait%0d", i), O_WAIT, 1'b1);
         chk($sformatf("wd.err%0d", i), {31'd0, a_err}, 32'd0);
         next_cycle();
      end
      chk("wd.a_err", {31'd0, a_err}, 32'd1);
      chk("wd.b_err", {31'd0, b_err}, 32'd1);
      chk("wd.busy", {31'd0, a_busy}, 32'd0);
      chk("wd.cnt", {16'd0, a_stall_cnt}, 32'd7);

      // Later traffic: store rt dependency stalls, lw rt does not; err stays set
      drive(1'b1, I_SW_R5, 1'b1, 5'd5, 1'b0);
      settle();
      chk_a("sw.rt_stall", O_STALL, 1'b0);
      next_cycle();
      chk("sw.err", {31'd0, a_err}, 32'd1);
      chk("sw.cnt", {16'd0, a_stall_cnt}, 32'd8);
      drive(1'b1, I_LW_R5, 1'b1, 5'd5, 1'b0);
      settle();
      chk_a("lw.rt_free", O_RUN, 1'b0);
      next_cycle();
      drive(1'b0, I_ADD_R2, 1'b1, 5'd2, 1'b0);
      settle();
      chk_a("bubble.nostall", O_RUN, 1'b0);
      next_cycle();
      chk("final.err", {31'd0, a_err}, 32'd1);
      chk("final.cnt", {16'd0, a_stall_cnt}, 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
